// File: rtl/fp32_divider_iter.sv
// Iterative fp32 divider: radix-2 restoring mantissa divide, one quotient bit per clock.
// Define FPDIV_ROUND_EN for round-to-nearest-even; otherwise the quotient is truncated.
//
// state  | meaning
// IDLE   | ready, waiting for i_vld
// UNPACK | split and classify operands; specials jump straight to OUT
// DIV    | QBITS restoring-divide iterations
// NORM   | normalise, round, range-check exponent
// OUT    | publish result and flags, pulse o_res_vld
module fp32_divider_iter #(
  parameter int          QBITS = 26,
  parameter logic [31:0] QNAN  = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_vld,
  output logic        o_rdy,
  output logic [31:0] o_res,
  output logic        o_res_vld,
  output logic        overflow,
  output logic        o_dz
);

  localparam int CNT_W = $clog2(QBITS);

  typedef enum logic [2:0] {IDLE, UNPACK, DIV, NORM, OUT} state_t;

  state_t             state;
  logic [31:0]        a_q, b_q;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [23:0]        mb_q;
  logic [24:0]        rem_q;
  logic [QBITS-1:0]   quo_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        res_pre;
  logic               ovf_pre, dz_pre;

  // operand classification
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special, sign_ab;
  logic [31:0] spec_res;
  logic        spec_dz;

  always_comb begin
    ea      = a_q[30:23];
    eb      = b_q[30:23];
    fa      = a_q[22:0];
    fb      = b_q[22:0];
    sign_ab = a_q[31] ^ b_q[31];
    a_nan   = (ea == 8'hFF) && (fa != 23'd0);
    b_nan   = (eb == 8'hFF) && (fb != 23'd0);
    a_inf   = (ea == 8'hFF) && (fa == 23'd0);
    b_inf   = (eb == 8'hFF) && (fb == 23'd0);
    a_zero  = (ea == 8'h00);
    b_zero  = (eb == 8'h00);
    special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    spec_dz = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero))
      spec_res = QNAN;
    else if (a_inf)
      spec_res = {sign_ab, 8'hFF, 23'd0};
    else if (b_zero) begin
      spec_res = {sign_ab, 8'hFF, 23'd0};
      spec_dz  = 1'b1;
    end else
      spec_res = {sign_ab, 31'd0};
  end

  // one restoring-divide step
  logic [25:0] diff;
  logic        qbit;
  logic [24:0] rem_next;

  always_comb begin
    diff     = {1'b0, rem_q} - {2'b00, mb_q};
    qbit     = ~diff[25];
    rem_next = qbit ? {diff[23:0], 1'b0} : {rem_q[23:0], 1'b0};
  end

  // normalise, round and range-check
  logic [QBITS-1:0]  norm_q;
  logic signed [9:0] exp_n, exp_r;
  logic [23:0]       mant;
  logic [2:0]        grs;
  logic              round_inc;
  logic [24:0]       mant_r;
  logic [31:0]       norm_res;
  logic              norm_ovf;

  always_comb begin
    norm_q = quo_q[QBITS-1] ? quo_q : {quo_q[QBITS-2:0], 1'b0};
    exp_n  = quo_q[QBITS-1] ? exp_q : exp_q - 10'sd1;
    mant   = norm_q[QBITS-1 -: 24];
    grs    = {norm_q[QBITS-25], norm_q[QBITS-26], |rem_q};
`ifdef FPDIV_ROUND_EN
    round_inc = grs[2] & (grs[1] | grs[0] | mant[0]);
`else
    // truncation: guard, round and sticky are dropped
    round_inc = |(grs & 3'b000);
`endif
    mant_r   = {1'b0, mant} + {24'd0, round_inc};
    exp_r    = exp_n + $signed({9'd0, mant_r[24]});
    norm_ovf = 1'b0;
    if (exp_r >= 10'sd255) begin
      norm_res = {sign_q, 8'hFF, 23'd0};
      norm_ovf = 1'b1;
    end else if (exp_r <= 10'sd0)
      norm_res = {sign_q, 31'd0};
    else
      norm_res = {sign_q, exp_r[7:0], mant_r[22:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      o_rdy     <= 1'b1;
      o_res     <= 32'd0;
      o_res_vld <= 1'b0;
      overflow  <= 1'b0;
      o_dz      <= 1'b0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      sign_q    <= 1'b0;
      exp_q     <= 10'sd0;
      mb_q      <= 24'd0;
      rem_q     <= 25'd0;
      quo_q     <= '0;
      cnt_q     <= '0;
      res_pre   <= 32'd0;
      ovf_pre   <= 1'b0;
      dz_pre    <= 1'b0;
    end else begin
      o_res_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (i_vld) begin
            a_q   <= i_a;
            b_q   <= i_b;
            o_rdy <= 1'b0;
            state <= UNPACK;
          end
        end
        UNPACK: begin
          sign_q <= sign_ab;
          if (special) begin
            res_pre <= spec_res;
            ovf_pre <= 1'b0;
            dz_pre  <= spec_dz;
            state   <= OUT;
          end else begin
            exp_q <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
            rem_q <= {2'b01, fa};
            mb_q  <= {1'b1, fb};
            quo_q <= '0;
            cnt_q <= CNT_W'(QBITS - 1);
            state <= DIV;
          end
        end
        DIV: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[QBITS-2:0], qbit};
          if (cnt_q == '0)
            state <= NORM;
          else
            cnt_q <= cnt_q - 1'b1;
        end
        NORM: begin
          res_pre <= norm_res;
          ovf_pre <= norm_ovf;
          dz_pre  <= 1'b0;
          state   <= OUT;
        end
        OUT: begin
          o_res     <= res_pre;
          overflow  <= ovf_pre;
          o_dz      <= dz_pre;
          o_res_vld <= 1'b1;
          o_rdy     <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          o_rdy <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_divider_iter.sv
// Directed-vector bench for fp32_divider_iter; expected values hand-computed.
// Honours FPDIV_ROUND_EN the same way the design does.
module tb_fp32_divider_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_a, i_b;
  logic        i_vld;
  logic        o_rdy;
  logic [31:0] o_res;
  logic        o_res_vld;
  logic        overflow;
  logic        o_dz;

  int checks   = 0;
  int failures = 0;

  fp32_divider_iter dut (
    .clk       (clk),
    .rst       (rst),
    .i_a       (i_a),
    .i_b       (i_b),
    .i_vld     (i_vld),
    .o_rdy     (o_rdy),
    .o_res     (o_res),
    .o_res_vld (o_res_vld),
    .overflow  (overflow),
    .o_dz      (o_dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        dz;
    int          lat;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs[NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one operation (caller is between clock edges with o_rdy high) and wait for the result.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic ovf, output logic dz,
                        output int lat);
    int c;
    i_a   = a;
    i_b   = b;
    i_vld = 1'b1;
    @(posedge clk);
    #1;
    i_vld = 1'b0;
    lat = -1;
    c   = 0;
    while (lat < 0 && c < 60) begin
      @(posedge clk);
      #1;
      c++;
      if (o_res_vld) lat = c;
    end
    res = o_res;
    ovf = overflow;
    dz  = o_dz;
  endtask

  logic [31:0] r;
  logic        ov, dz;
  int          lat;
  logic        seen;
  logic [31:0] third;

  initial begin
`ifdef FPDIV_ROUND_EN
    third = 32'h3EAAAAAB;
`else
    third = 32'h3EAAAAAA;
`endif
    vecs[0]  = '{32'h40E00000, 32'h40000000, 32'h40600000, 1'b0, 1'b0, 29};
    vecs[1]  = '{32'hC0C00000, 32'h40800000, 32'hBFC00000, 1'b0, 1'b0, 29};
    vecs[2]  = '{32'h3F800000, 32'h40400000, third,        1'b0, 1'b0, 29};
    vecs[3]  = '{32'h40A00000, 32'h00000000, 32'h7F800000, 1'b0, 1'b1, 2};
    vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0, 2};
    vecs[5]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0, 2};
    vecs[6]  = '{32'h60AD78EC, 32'h1E3CE508, 32'h7F800000, 1'b1, 1'b0, 29};
    vecs[7]  = '{32'h1E3CE508, 32'h60AD78EC, 32'h00000000, 1'b0, 1'b0, 29};
    vecs[8]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b0, 1'b0, 2};
    vecs[9]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b0, 2};
    vecs[10] = '{32'h80000000, 32'h40A00000, 32'h80000000, 1'b0, 1'b0, 2};
    vecs[11] = '{32'h40000000, 32'h7F800000, 32'h00000000, 1'b0, 1'b0, 2};
    vecs[12] = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 1'b0, 1'b0, 29};
    vecs[13] = '{32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b1, 1'b0, 29};
    vecs[14] = '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 29};
    vecs[15] = '{32'h00400000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 2};
    vecs[16] = '{32'h40400000, 32'hC0400000, 32'hBF800000, 1'b0, 1'b0, 29};
    vecs[17] = '{32'h00000000, 32'h7F800000, 32'h00000000, 1'b0, 1'b0, 2};
    vecs[18] = '{32'hC0C00000, 32'h00000000, 32'hFF800000, 1'b0, 1'b1, 2};

    rst   = 1'b0;
    i_a   = 32'd0;
    i_b   = 32'd0;
    i_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy", {31'd0, o_rdy}, 32'd1);
    chk("reset_res", o_res, 32'd0);
    chk("reset_vld", {31'd0, o_res_vld}, 32'd0);
    chk("reset_ovf", {31'd0, overflow}, 32'd0);
    chk("reset_dz",  {31'd0, o_dz}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].a, vecs[i].b, r, ov, dz, lat);
      chk($sformatf("v%0d_res", i), r, vecs[i].res);
      chk($sformatf("v%0d_ovf", i), {31'd0, ov}, {31'd0, vecs[i].ovf});
      chk($sformatf("v%0d_dz", i),  {31'd0, dz}, {31'd0, vecs[i].dz});
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      @(negedge clk);
    end

    // back-to-back: second accept on the edge right after the o_res_vld cycle
    run_op(32'hC0C00000, 32'h40800000, r, ov, dz, lat);
    chk("b2b_first_res", r, 32'hBFC00000);
    chk("b2b_first_lat", 32'(lat), 32'd29);
    run_op(32'h40E00000, 32'h40000000, r, ov, dz, lat);
    chk("b2b_second_res", r, 32'h40600000);
    chk("b2b_second_lat", 32'(lat), 32'd29);

    // busy-drop then reset abort
    i_a   = 32'h40E00000;
    i_b   = 32'h40000000;
    i_vld = 1'b1;
    @(posedge clk);
    #1;
    i_vld = 1'b0;
    chk("abort_busy_after_accept", {31'd0, o_rdy}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    i_a   = 32'h3F800000;
    i_b   = 32'h3F800000;
    i_vld = 1'b1;
    @(posedge clk);
    #1;
    chk("ignored_vld_rdy", {31'd0, o_rdy}, 32'd0);
    i_vld = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_rdy", {31'd0, o_rdy}, 32'd1);
    chk("abort_res", o_res, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (o_res_vld) seen = 1'b1;
    end
    chk("abort_no_vld", {31'd0, seen}, 32'd0);

    @(negedge clk);
    run_op(32'h3F800000, 32'h3F800000, r, ov, dz, lat);
    chk("post_abort_res", r, 32'h3F800000);
    chk("post_abort_lat", 32'(lat), 32'd29);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
